// File: rtl/processor_pivot.sv
// processor_pivot: pivot cell at the head of one row of the GF(2^m)
// Gaussian-elimination systolic array. It classifies each row's leading
// element and drives the op/fac bus of the row's B-type cells. A nonzero
// element arriving while no pivot is stored is inverted by iterated
// squaring, and the upstream stream is stalled while that runs.
module processor_pivot #(
   parameter int             WIDTH = 13,
   parameter logic [WIDTH:0] POLY  = 14'h201B
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             start_in,
   input  logic             flush_in,
   output logic             valid_out,
   output logic             start_out,
   output logic [1:0]       op_out,
   output logic [WIDTH-1:0] fac_out,
   output logic [WIDTH-1:0] data_out,
   output logic             pivot,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_PASS   = 2'b00;
   localparam logic [1:0] OP_SWAP   = 2'b01;
   localparam logic [1:0] OP_ELIM   = 2'b10;
   localparam logic [1:0] OP_INVADD = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      INV  = 1'b1
   } state_t;

   state_t           state, state_next;
   logic             pivot_set, pivot_next;
   logic             start_hold, start_hold_next;
   logic [WIDTH-1:0] x_reg, x_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [CW-1:0]    cnt_reg, cnt_next;

   logic             valid_next;
   logic             start_next;
   logic [1:0]       op_next;
   logic [WIDTH-1:0] fac_next;
   logic [WIDTH-1:0] data_next;

   logic [WIDTH-1:0] x_sq;
   logic [WIDTH-1:0] acc_mul;
   logic             pivot_eff;

   // Field multiply with the reduction folded into each shift step, so the
   // result is always below 2^WIDTH.
   function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH:0]   sh;
      logic [WIDTH-1:0] p;
      p  = '0;
      sh = {1'b0, a};
      for (int i = 0; i < WIDTH; i++) begin
         if (b[i]) begin
            p = p ^ sh[WIDTH-1:0];
         end
         sh = sh << 1;
         if (sh[WIDTH]) begin
            sh = sh ^ POLY;
         end
      end
      return p;
   endfunction

   // One inverter step: square x, then fold the new square into acc.
   assign x_sq    = gf_mul(x_reg, x_reg);
   assign acc_mul = gf_mul(acc_reg, x_sq);

   // A start beat wipes any stored pivot before the beat is classified.
   assign pivot_eff = pivot_set & ~start_in;

   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;
   assign pivot    = pivot_set;

   // Next-state, inverter datapath and next output beat; idle beat by default.
   always_comb begin
      state_next      = state;
      pivot_next      = pivot_set;
      start_hold_next = start_hold;
      x_next          = x_reg;
      acc_next        = acc_reg;
      cnt_next        = cnt_reg;
      valid_next      = 1'b0;
      start_next      = 1'b0;
      op_next         = OP_PASS;
      fac_next        = '0;
      data_next       = '0;

      unique case (state)
         IDLE: begin
            if (in_valid) begin
               valid_next = 1'b1;
               start_next = start_in;
               pivot_next = pivot_eff;
               if (flush_in) begin
                  op_next    = OP_SWAP;
                  data_next  = WIDTH'(pivot_eff);
                  pivot_next = 1'b0;
               end else if (pivot_eff) begin
                  op_next  = OP_ELIM;
                  fac_next = data_in;
               end else if (data_in == '0) begin
                  op_next = OP_PASS;
               end else begin
                  valid_next      = 1'b0;
                  start_next      = 1'b0;
                  start_hold_next = start_in;
                  x_next          = data_in;
                  acc_next        = WIDTH'(1);
                  cnt_next        = CW'(WIDTH - 1);
                  state_next      = INV;
               end
            end
         end
         INV: begin
            x_next   = x_sq;
            acc_next = acc_mul;
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               state_next      = IDLE;
               valid_next      = 1'b1;
               start_next      = start_hold;
               op_next         = OP_INVADD;
               fac_next        = acc_mul;
               pivot_next      = 1'b1;
               start_hold_next = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, inverter registers and the registered output beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pivot_set  <= 1'b0;
         start_hold <= 1'b0;
         x_reg      <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         valid_out  <= 1'b0;
         start_out  <= 1'b0;
         op_out     <= OP_PASS;
         fac_out    <= '0;
         data_out   <= '0;
      end else begin
         state      <= state_next;
         pivot_set  <= pivot_next;
         start_hold <= start_hold_next;
         x_reg      <= x_next;
         acc_reg    <= acc_next;
         cnt_reg    <= cnt_next;
         valid_out  <= valid_next;
         start_out  <= start_next;
         op_out     <= op_next;
         fac_out    <= fac_next;
         data_out   <= data_next;
      end
   end

endmodule

// File: tb/tb_processor_pivot.sv
// tb_processor_pivot: directed bench for the pivot cell. Two instances are
// exercised: WIDTH=4 with POLY 5'h13 and the WIDTH=13 default. A cycle-indexed
// model of the expected output beats is filled by the stimulus tasks and
// checked every cycle, alongside hand-computed literal expectations.
module tb_processor_pivot;

   localparam int MAXC = 16384;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   logic        iv  [0:1];
   logic [15:0] din [0:1];
   logic        st  [0:1];
   logic        fl  [0:1];

   logic        rdy4, vo4, so4, pv4, bz4;
   logic [1:0]  op4;
   logic [3:0]  fac4, do4;
   logic        rdy13, vo13, so13, pv13, bz13;
   logic [1:0]  op13;
   logic [12:0] fac13, do13;

   // {valid, start, op, fac, data, pivot, ready, busy}
   logic [38:0] got [0:1];

   // Expected beat per DUT per cycle: {valid, start, op, fac, data}
   logic [35:0] exp_beat [0:1][0:MAXC-1];
   logic [1:0]  piv_evt  [0:1][0:MAXC-1];
   logic        pin_on   [0:1][0:MAXC-1];
   logic [38:0] pin_vec  [0:1][0:MAXC-1];
   logic        model_piv   [0:1];
   int          stall_start [0:1];
   int          stall_end   [0:1];
   logic        cur_piv     [0:1] = '{1'b0, 1'b0};

   int n_checks = 0;
   int n_errors = 0;

   processor_pivot #(.WIDTH(4), .POLY(5'h13)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy4),
      .data_in(din[0][3:0]), .start_in(st[0]), .flush_in(fl[0]),
      .valid_out(vo4), .start_out(so4), .op_out(op4), .fac_out(fac4),
      .data_out(do4), .pivot(pv4), .busy(bz4)
   );

   processor_pivot dut13 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy13),
      .data_in(din[1][12:0]), .start_in(st[1]), .flush_in(fl[1]),
      .valid_out(vo13), .start_out(so13), .op_out(op13), .fac_out(fac13),
      .data_out(do13), .pivot(pv13), .busy(bz13)
   );

   assign got[0] = {vo4, so4, op4, 12'd0, fac4, 12'd0, do4, pv4, rdy4, bz4};
   assign got[1] = {vo13, so13, op13, 3'd0, fac13, 3'd0, do13, pv13, rdy13, bz13};

   always #5 clk = ~clk;

   // Edge counter: at a falling edge, cyc is the index of the last rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [35:0] beat(input logic v, input logic s, input logic [1:0] op,
                                        input logic [15:0] fac, input logic [15:0] dat);
      return {v, s, op, fac, dat};
   endfunction

   function automatic logic [38:0] vec(input logic v, input logic s, input logic [1:0] op,
                                       input logic [15:0] fac, input logic [15:0] dat,
                                       input logic p, input logic r);
      return {v, s, op, fac, dat, p, r, ~r};
   endfunction

   // Schoolbook carry-less product followed by polynomial long division.
   function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b,
                                           input int w, input int unsigned poly);
      int unsigned p;
      p = 0;
      for (int i = 0; i < w; i++) begin
         if (b[i]) p = p ^ (a << i);
      end
      for (int i = 2 * w - 2; i >= w; i--) begin
         if (p[i]) p = p ^ (poly << (i - w));
      end
      return p;
   endfunction

   // Inverse found by exhaustive search over the field.
   function automatic int unsigned ref_inv(input int unsigned a, input int w,
                                           input int unsigned poly);
      for (int unsigned b = 1; b < (32'd1 << w); b++) begin
         if (ref_mul(a, b, w, poly) == 1) return b;
      end
      return 0;
   endfunction

   task automatic clearSlot(input int s, input int k);
      exp_beat[s][k] = '0;
      piv_evt[s][k]  = 2'b00;
      pin_on[s][k]   = 1'b0;
      pin_vec[s][k]  = '0;
   endtask

   task automatic setBeat(input int s, input int k, input logic [35:0] b);
      if (k < MAXC) exp_beat[s][k] = b;
   endtask

   task automatic setPiv(input int s, input int k, input logic v);
      if (k < MAXC) piv_evt[s][k] = {1'b1, v};
   endtask

   task automatic pinAt(input int s, input int k, input logic [38:0] v);
      if (k < MAXC) begin
         pin_on[s][k]  = 1'b1;
         pin_vec[s][k] = v;
      end
   endtask

   task automatic checkOutput(input string name, input int s,
                              input logic [38:0] g, input logic [38:0] w);
      n_checks++;
      if (g !== w) begin
         n_errors++;
         $display("[TB] FAIL %s dut%0d cyc %0d got %h want %h", name, s, cyc, g, w);
      end
   endtask

   // Drive one beat at a falling edge; junk is offered while the model says
   // the cell is stalled. The model records the expected beat and pivot flag.
   task automatic applyStimulus(input int s, input int unsigned a, input logic s_in,
                                input logic f_in, input int pin_off,
                                input logic [38:0] pv, output int t);
      int          w;
      int unsigned poly;
      int unsigned inv;
      logic        pe;
      w    = (s == 0) ? 4 : 13;
      poly = (s == 0) ? 32'h13 : 32'h201B;
      while (cyc >= stall_start[s] && cyc < stall_end[s]) begin
         iv[s]  = 1'b1;
         din[s] = 16'($urandom);
         st[s]  = 1'($urandom_range(0, 1));
         fl[s]  = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      iv[s]  = 1'b1;
      din[s] = 16'(a);
      st[s]  = s_in;
      fl[s]  = f_in;
      t  = cyc + 1;
      pe = s_in ? 1'b0 : model_piv[s];
      if (f_in) begin
         setBeat(s, t, beat(1'b1, s_in, 2'd1, 16'd0, {15'd0, pe}));
         setPiv(s, t, 1'b0);
         model_piv[s] = 1'b0;
      end else if (pe) begin
         setBeat(s, t, beat(1'b1, s_in, 2'd2, 16'(a), 16'd0));
         setPiv(s, t, 1'b1);
      end else if (a == 0) begin
         setBeat(s, t, beat(1'b1, s_in, 2'd0, 16'd0, 16'd0));
         setPiv(s, t, 1'b0);
         model_piv[s] = 1'b0;
      end else begin
         inv            = ref_inv(a, w, poly);
         stall_start[s] = t;
         stall_end[s]   = t + w - 1;
         setPiv(s, t, 1'b0);
         setBeat(s, t + w - 1, beat(1'b1, s_in, 2'd3, 16'(inv), 16'd0));
         setPiv(s, t + w - 1, 1'b1);
         model_piv[s] = 1'b1;
      end
      if (pin_off >= 0) pinAt(s, t + pin_off, pv);
      @(negedge clk);
      iv[s] = 1'b0;
   endtask

   task automatic idle(input int n);
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Pulse reset between falling edges and discard everything the model
   // still expected from the cells.
   task automatic doReset();
      #2 rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         model_piv[s]   = 1'b0;
         stall_start[s] = 0;
         stall_end[s]   = 0;
         iv[s]          = 1'b0;
         for (int k = cyc + 1; k < MAXC; k++) clearSlot(s, k);
      end
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Compare process: idle values while reset is low (also right after it
   // falls), otherwise model plus any literal pin for this cycle.
   initial begin : compare
      logic [38:0] want;
      logic        r;
      forever begin
         @(negedge clk or negedge rst_n);
         if (rst_n !== 1'b1) begin
            #1;
            for (int s = 0; s < 2; s++) begin
               cur_piv[s] = 1'b0;
               checkOutput("reset", s, got[s],
                           vec(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 1'b1));
            end
         end else if (cyc < MAXC) begin
            for (int s = 0; s < 2; s++) begin
               if (piv_evt[s][cyc][1]) cur_piv[s] = piv_evt[s][cyc][0];
               r    = !(cyc >= stall_start[s] && cyc < stall_end[s]);
               want = {exp_beat[s][cyc], cur_piv[s], r, ~r};
               checkOutput("model", s, got[s], want);
               if (pin_on[s][cyc]) checkOutput("pin", s, got[s], pin_vec[s][cyc]);
            end
         end
      end
   end

   initial begin : stimulus
      int t;
      for (int s = 0; s < 2; s++) begin
         model_piv[s]   = 1'b0;
         stall_start[s] = 0;
         stall_end[s]   = 0;
         iv[s]          = 1'b0;
         din[s]         = '0;
         st[s]          = 1'b0;
         fl[s]          = 1'b0;
         for (int k = 0; k < MAXC; k++) clearSlot(s, k);
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // WIDTH=4: new matrix, a=2 stalls three cycles then inverts to 9
      applyStimulus(0, 2, 1'b1, 1'b0, 3,
                    vec(1'b1, 1'b1, 2'd3, 16'h9, 16'd0, 1'b1, 1'b1), t);
      pinAt(0, t + 1, vec(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0));
      pinAt(0, t + 2, vec(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0));

      // Eliminations back to back, one per cycle
      applyStimulus(0, 7, 1'b0, 1'b0, 0,
                    vec(1'b1, 1'b0, 2'd2, 16'h7, 16'd0, 1'b1, 1'b1), t);
      applyStimulus(0, 0, 1'b0, 1'b0, 0,
                    vec(1'b1, 1'b0, 2'd2, 16'h0, 16'd0, 1'b1, 1'b1), t);

      // New matrix with zero lead, then a=1 inverts to itself
      applyStimulus(0, 0, 1'b1, 1'b0, 0,
                    vec(1'b1, 1'b1, 2'd0, 16'd0, 16'd0, 1'b0, 1'b1), t);
      applyStimulus(0, 1, 1'b0, 1'b0, 3,
                    vec(1'b1, 1'b0, 2'd3, 16'h1, 16'd0, 1'b1, 1'b1), t);

      // Two drain beats: first reports the stored pivot, second does not
      applyStimulus(0, 0, 1'b0, 1'b1, 0,
                    vec(1'b1, 1'b0, 2'd1, 16'd0, 16'd1, 1'b0, 1'b1), t);
      applyStimulus(0, 0, 1'b0, 1'b1, 0,
                    vec(1'b1, 1'b0, 2'd1, 16'd0, 16'd0, 1'b0, 1'b1), t);
      idle(2);

      // Reset in the middle of an inversion
      applyStimulus(0, 3, 1'b0, 1'b0, -1, '0, t);
      doReset();
      idle(4);

      // Reset while an elimination beat is on the outputs with pivot stored
      applyStimulus(0, 5, 1'b0, 1'b0, -1, '0, t);
      applyStimulus(0, 6, 1'b0, 1'b0, 0,
                    vec(1'b1, 1'b0, 2'd2, 16'h6, 16'd0, 1'b1, 1'b1), t);
      doReset();

      // After reset: a=4 inverts to 0xD; then a start+flush beat drains nothing
      applyStimulus(0, 4, 1'b0, 1'b0, 3,
                    vec(1'b1, 1'b0, 2'd3, 16'hD, 16'd0, 1'b1, 1'b1), t);
      applyStimulus(0, 4, 1'b1, 1'b1, 0,
                    vec(1'b1, 1'b1, 2'd1, 16'd0, 16'd0, 1'b0, 1'b1), t);
      idle(2);

      // WIDTH=13: a=1 after a 12-cycle stall
      applyStimulus(1, 1, 1'b1, 1'b0, 12,
                    vec(1'b1, 1'b1, 2'd3, 16'h1, 16'd0, 1'b1, 1'b1), t);
      pinAt(1, t + 11, vec(1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 1'b0));

      // WIDTH=13: random nonzero leads, each opening a new matrix
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1, $urandom_range(1, 8191), 1'b1, 1'b0, -1, '0, t);
      end

      // Largest element eliminated against the stored pivot
      applyStimulus(1, 8191, 1'b0, 1'b0, 0,
                    vec(1'b1, 1'b0, 2'd2, 16'h1FFF, 16'd0, 1'b1, 1'b1), t);
      idle(16);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/processor_pivot.md
# processor_pivot

Pivot cell at the head of each row of the GF(2^m) Gaussian-elimination systolic array. It drives the row's chain of B-type cells through their `op`/`fac` bus. It receives the leading element of every streamed matrix row and decides pass / normalize-and-store (with field inversion) / eliminate / drain. It emits registered `op_out`, `fac_out`, `data_out` and `start_out` to the first B cell. An iterative inverter stalls the upstream stream through a valid/ready handshake; while stalled, the cell emits idle beats (op 00 = pass) that leave B cells unchanged.

## Interface
- `WIDTH`, default 13: field element width m; legal range 2..16.
- `POLY`, default 14'h201B: WIDTH+1-bit reduction polynomial (x^13+x^4+x^3+x+1). Identical to the polynomial used by the B cells.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream element present.
- `in_ready` output 1: cell can accept; transfer occurs when in_valid & in_ready at a rising edge.
- `data_in` input WIDTH: leading element a of the row.
- `start_in` input 1: accepted element is the first row of a new matrix.
- `flush_in` input 1: accepted beat is a drain beat; data_in ignored.
- `valid_out` output 1: one-cycle pulse marking a decision beat.
- `start_out` output 1: registered copy of accepted start_in.
- `op_out` output 2: 00 pass, 01 swap, 10 eliminate, 11 inv-add.
- `fac_out` output WIDTH: factor for B cells.
- `data_out` output WIDTH: residual leading element passed downward.
- `pivot` output 1: pivot_set flag, meaning a normalized pivot row is stored in the row.
- `busy` output 1: inverter running; equal to ~in_ready.

## Operation
- FSM states: IDLE (in_ready=1) and INV (in_ready=0).
- On an accepted beat, start_in clears pivot_set first. The cleared value is then used for this beat's decision.
- Decision for an accepted beat, in priority order:
  - flush_in: op 01, fac 0, data_out = pivot_set ? 1 : 0. Clear pivot_set. Stay in IDLE.
  - pivot_set=1: op 10, fac = a, data_out 0. Stay in IDLE.
  - pivot_set=0, a=0: op 00, fac 0, data_out 0. Stay in IDLE.
  - pivot_set=0, a≠0: go to INV. After the inversion completes, emit op 11, fac = a^-1, data_out 0, and set pivot_set.
- Inverter computes a^(2^WIDTH−2) by iterated squaring:
  - On the acceptance edge, load x←a, acc←1, cnt←WIDTH−1.
  - Each INV cycle: x←x², acc←acc·x_new, cnt←cnt−1.
  - On the edge where cnt goes 1→0: register the op-11 outputs from the final acc and return to IDLE.
- Multiplier and squarer are combinational, fully reduced modulo POLY. Outputs are always reduced (< 2^WIDTH).
- Idle beat, on every cycle without a fresh decision: valid_out 0, start_out 0, op 00, fac 0, data_out 0.
- Reset (rst_n=0, at any time including mid-INV): state IDLE, pivot_set 0, x/acc/cnt 0. All outputs take idle-beat values; in_ready 1 during and after reset. An inversion in flight is discarded.

## Timing
- Non-inverse beat: accepted at edge T; outputs valid in cycle T..T+1 (registered, latency 1).
- Inverse beat: accepted at edge T; in_ready=0 from edge T until edge T+WIDTH−1; op-11 outputs valid for one cycle after edge T+WIDTH−1. in_ready is 1 again in that same cycle, so the next accept is at edge T+WIDTH at the earliest.
- Back-to-back non-inverse beats sustain one beat per cycle.
- start_out and valid_out are registered together with op_out and cover exactly one cycle per accepted beat.
- data_in, start_in and flush_in are sampled only at an acceptance edge. Input changes during INV are ignored.

## Test plan
Use WIDTH=4, POLY=5'h13 unless noted.
- Reset: assert rst_n=0 mid-INV. Outputs go idle immediately (asynchronous), pivot=0, in_ready=1.
- start_in=1, a=2: in_ready low for 3 cycles, then one beat op=11, fac=9, data_out=0; pivot=1.
- Then a=7, then a=0, back-to-back: beats op=10 fac=7, then op=10 fac=0, one per cycle with no stall.
- New matrix: start_in=1 with a=0: op=00, pivot=0, start_out=1. Then a=1: op=11, fac=1 after 3 cycles.
- With pivot=1, flush_in=1: op=01, data_out=1, pivot cleared. A second flush gives op=01, data_out=0.
- WIDTH=13 default: a=1 gives fac=1 after a 12-cycle stall. Random nonzero a gives a·fac ≡ 1 mod POLY, checked against a reference model over 1000 samples.
